// File: rtl/apb_slave_pkg.sv
// Shared types and sizing helpers for the APB slave register bank.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 3;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // First byte address outside the backing memory.
  function automatic longint err_base(input int depth, input int dw);
    return longint'(depth) * longint'(dw / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// Byte-enabled word memory: sync write, comb read, async clear on rst.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int IW    = idx_w(DEPTH),
  parameter int SW    = strb_w(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [SW-1:0] wstrb,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < SW; b++)
        if (wstrb[b])
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer backed by a byte-strobed word memory with wait states.
// Optional error response enabled by macro APB_SLAVE_SLVERR_EN.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr
);

  localparam int SW = strb_w(DATA_WIDTH);
  localparam int IW = idx_w(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT0 = CNT_W'(WAIT_CYCLES);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  write_q;
  logic [SW-1:0]         strb_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic                  err_d;
  logic                  we;
  logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef APB_SLAVE_SLVERR_EN
  localparam longint LIMIT = err_base(MEM_DEPTH, DATA_WIDTH);
  logic [SW-1:0] low_mask;
  logic          oob;

  // Lanes strictly below the byte offset are illegal for a misaligned access.
  assign low_mask = SW'((4'b0001 << addr[1:0]) - 4'b0001);
  assign oob      = 64'(addr) >= 64'(LIMIT);
  assign err_d    = oob | (|(strb & low_mask));
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel && !enable) begin
            write_q <= write;
            strb_q  <= strb;
            idx_q   <= addr[IW+1:2];
            wdata_q <= wdata;
            err_q   <= err_d;
            cnt     <= CNT0;
            state   <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == DONE);
  assign we     = ready & sel & enable & write_q & ~err_q;
  assign rdata  = (ready && !write_q && !err_q) ? mem_rdata : '0;
  assign slverr = ready & err_q;

  apb_slave_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (MEM_DEPTH),
    .IW    (IW),
    .SW    (SW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .idx   (idx_q),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank at WAIT_CYCLES 0, 3 and 5.
module tb_apb_slave_regbank;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       sel;
  logic             enable;
  logic             write;
  logic [3:0]       strb;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [2:0][31:0] rdata;
  logic [2:0]       ready;
  logic [2:0]       slverr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable),
    .write(write), .strb(strb), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .ready(ready[0]), .slverr(slverr[0])
  );

  apb_slave_regbank #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable),
    .write(write), .strb(strb), .addr(addr), .wdata(wdata),
    .rdata(rdata[1]), .ready(ready[1]), .slverr(slverr[1])
  );

  apb_slave_regbank #(.WAIT_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .sel(sel[2]), .enable(enable),
    .write(write), .strb(strb), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .ready(ready[2]), .slverr(slverr[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int k, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rd, output logic er,
                      output int cyc);
    @(negedge clk);
    sel    = '0;
    sel[k] = 1'b1;
    enable = 1'b0;
    write  = wr;
    addr   = a;
    wdata  = d;
    strb   = s;
    @(negedge clk);
    enable = 1'b1;
    cyc    = 1;
    while (!ready[k] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready[k])
      chk("timeout", {31'b0, ready[k]}, 32'd1);
    rd = rdata[k];
    er = slverr[k];
    @(negedge clk);
    sel    = '0;
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic [2:0]  seen;

    rst    = 1'b1;
    sel    = '0;
    enable = 1'b0;
    write  = 1'b0;
    strb   = '0;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'b0, ready}, 32'd0);
    chk("rst_slverr", {29'b0, slverr}, 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_rdata5", rdata[2], 32'd0);
    rst = 1'b0;

    // zero-wait write then read
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    chk("w0_lat", 32'(cyc), 32'd1);
    chk("w0_rdata", rd, 32'd0);
    chk("w0_slverr", {31'b0, er}, 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("r0_lat", 32'(cyc), 32'd1);
    chk("r0_data", rd, 32'hDEADBEEF);

    // three wait states on a fresh location
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("r3_lat", 32'(cyc), 32'd4);
    chk("r3_data", rd, 32'd0);

    // byte strobes
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h4, rd, er, cyc);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    chk("strb4_data", rd, 32'h11BB3344);
    xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
    chk("strb0_lat", 32'(cyc), 32'd1);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    chk("strb0_data", rd, 32'h11BB3344);

    // enable without setup is ignored
    @(negedge clk);
    sel[0] = 1'b1;
    enable = 1'b1;
    seen   = '0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ready;
    end
    chk("no_setup", {29'b0, seen}, 32'd0);
    sel    = '0;
    enable = 1'b0;

    // five wait states, then abort a write mid-wait
    xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, rd, er, cyc);
    chk("w5_lat", 32'(cyc), 32'd6);
    @(negedge clk);
    sel[2] = 1'b1;
    enable = 1'b0;
    write  = 1'b1;
    addr   = 32'h08;
    wdata  = 32'hFFFFFFFF;
    strb   = 4'hF;
    seen   = '0;
    @(negedge clk);
    enable = 1'b1;
    seen   = seen | ready;
    @(negedge clk);
    seen   = seen | ready;
    sel    = '0;
    enable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | ready;
    end
    chk("abort_ready", {29'b0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("abort_lat", 32'(cyc), 32'd6);
    chk("abort_data", rd, 32'h12345678);

    // out-of-range address
    xfer(0, 1'b1, 32'h00, 32'h0BADC0DE, 4'hF, rd, er, cyc);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, cyc);
    chk("oob_lat", 32'(cyc), 32'd1);
`ifdef APB_SLAVE_SLVERR_EN
    chk("oob_slverr", {31'b0, er}, 32'd1);
    chk("oob_rdata", rd, 32'd0);
`else
    chk("oob_slverr", {31'b0, er}, 32'd0);
    chk("oob_rdata", rd, 32'h0BADC0DE);
`endif

    // reset in the middle of a waited write
    xfer(1, 1'b1, 32'h10, 32'h55AA55AA, 4'hF, rd, er, cyc);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("r3_pre_rst", rd, 32'h55AA55AA);
    @(negedge clk);
    sel[1] = 1'b1;
    enable = 1'b0;
    write  = 1'b1;
    addr   = 32'h10;
    wdata  = 32'hCAFEF00D;
    strb   = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, ready[1]}, 32'd0);
    chk("midrst_rdata", rdata[1], 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    sel    = '0;
    enable = 1'b0;
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("postrst_u3", rd, 32'd0);
    chk("postrst_lat", 32'(cyc), 32'd4);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("postrst_u0", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
